alu16_seq: RTL

Multi-cycle sequencer that executes 16-bit ALU operations by driving a single 4-bit ALU slice over four consecutive nibbles, least-significant first. It chains the slice carry between nibbles and forms the final C/N/Z/V condition flags from the full 16-bit result. It sits between the instruction/control logic, which issues one operation with a start/done handshake, and the nibble datapath, which it owns exclusively.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu4_slice.sv | 32 +++
 rtl/alu16_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, sequencer states and slice width for the nibble-serial ALU
package alu_pkg;
    localparam int NIB_W = 4;
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_NOTA = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_SUB  = 3'b111;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu4_slice.sv
// alu4_slice: combinational 4-bit ALU slice; exposes the bit-3 carry-in so overflow can be formed upstream
module alu4_slice
    import alu_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             cin,
    output logic [NIB_W-1:0] r,
    output logic             co,
    output logic             c3
);
    logic [NIB_W-1:0] yy;
    logic [3:0]       lo;
    logic [1:0]       hi;
    always_comb begin
        yy = (op == OP_SUB) ? ~y : y;
        lo = {1'b0, x[2:0]} + {1'b0, yy[2:0]} + {3'b000, cin};
        hi = {1'b0, x[3]} + {1'b0, yy[3]} + {1'b0, lo[3]};
        c3 = lo[3];
        co = hi[1];
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_XNOR: r = ~(x ^ y);
            OP_NOTA: r = ~x;
            OP_PASS: r = x;
            default: r = {hi[0], lo[2:0]};
        endcase
    end
endmodule

// File: rtl/alu16_seq.sv
// alu16_seq: runs a 16-bit ALU op over one 4-bit slice, four nibbles LSB first, then flags the full word
module alu16_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        c,
    output logic        n,
    output logic        z,
    output logic        v
);
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d, result_q, result_d, full;
    logic        c_q, c_d, n_q, n_d, z_q, z_d, v_q, v_d;
    logic [NIB_W-1:0] r_s;
    logic        co_s, c3_s, arith;

    alu4_slice u_slice (
        .op  (op_q),
        .x   (a_q[{idx_q, 2'b00} +: NIB_W]),
        .y   (b_q[{idx_q, 2'b00} +: NIB_W]),
        .cin (carry_q),
        .r   (r_s),
        .co  (co_s),
        .c3  (c3_s)
    );

    assign arith = op_q[2:1] == 2'b11;
    assign full  = {r_s, result_q[11:0]};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        c_d      = c_q;
        n_d      = n_q;
        z_d      = z_q;
        v_d      = v_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = RUN;
                op_d     = op;
                a_d      = a;
                b_d      = b;
                idx_d    = 2'd0;
                carry_d  = op == OP_SUB;
                result_d = 16'h0000;
                {c_d, n_d, z_d, v_d} = 4'b0000;
            end
            RUN: begin
                result_d[{idx_q, 2'b00} +: NIB_W] = r_s;
                carry_d = co_s;
                idx_d   = idx_q + 2'd1;
                // last nibble: flags come from the completed word in the same edge
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                    c_d     = arith & co_s;
                    v_d     = arith & (co_s ^ c3_s);
                    n_d     = full[15];
                    z_d     = full == 16'h0000;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            carry_q  <= 1'b0;
            op_q     <= OP_AND;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            result_q <= 16'h0000;
            {c_q, n_q, z_q, v_q} <= 4'b0000;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            {c_q, n_q, z_q, v_q} <= {c_d, n_d, z_d, v_d};
        end
    end

    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
    assign result = result_q;
    assign {c, n, z, v} = {c_q, n_q, z_q, v_q};
endmodule
